fetch_unit: RTL
===============

# fetch_unit

Instruction fetch stage and IF/ID pipeline register: the producer of the instruction and incremented PC that flow toward decode and execute, and the consumer of execute's `take_branch_PC` / `newPC` redirect. It holds the architectural PC and issues one-outstanding requests to instruction memory over a req/ready + rvalid handshake. It buffers one returned instruction when decode stalls and discards in-flight fetches on redirect.

## Interface
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `clk`  in  1  system clock, all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `take_branch_PC`  in  1  redirect from execute, valid for one cycle.
- `newPC`  in  16  redirect target, sampled when `take_branch_PC`=1.
- `stall`  in  1  decode cannot accept IF/ID this cycle; IF/ID holds.
- `imem_req`  out  1  fetch request valid.
- `imem_addr`  out  16  fetch address (current PC).
- `imem_ready`  in  1  memory accepts request this cycle.
- `imem_rvalid`  in  1  read data valid (exactly one per accepted request, ≥1 cycle after acceptance).
- `imem_rdata`  in  16  instruction word.
- `instr`  out  16  IF/ID instruction.
- `PC_out`  out  16  IF/ID incremented PC (fetch address + 2).
- `instr_valid`  out  1  IF/ID holds a live instruction.
- `halted`  out  1  fetch stopped on HALT (see Configuration).
- `err`  out  1  sticky protocol error.

## Operation
- States: REQ, WAIT, DRAIN, HOLD, HALT. Registers: `pc`, IF/ID (`instr`, `PC_out`, `instr_valid`), one-entry skid (`skid_instr`, `skid_pc`).
- REQ: `imem_req`=1, `imem_addr`=`pc`. On `imem_ready` → WAIT.
- WAIT: on `imem_rvalid`:
  - IF/ID free (`instr_valid`=0 or `stall`=0): load IF/ID with `imem_rdata`, `pc`+2, valid=1; `pc`<=`pc`+2; → REQ.
  - else (`stall`=1, IF/ID full): load skid, `pc`<=`pc`+2; → HOLD.
- HOLD: no request. When `stall`=0: IF/ID <= skid; → REQ.
- IF/ID with `stall`=0 and no new load: `instr_valid` clears (bubble), `instr` and `PC_out` hold.
- Redirect (`take_branch_PC`=1) beats every other event in all states: `pc`<=`newPC`, `instr_valid`<=0, skid discarded.
  - From WAIT without `imem_rvalid`, or from REQ with `imem_ready`=1: → DRAIN (one response owed).
  - From WAIT with `imem_rvalid` same cycle: response dropped → REQ.
  - From REQ without `imem_ready`, HOLD, HALT, DRAIN with `imem_rvalid`: → REQ.
  - From DRAIN without `imem_rvalid`: stay in DRAIN, target updated.
- DRAIN: `imem_req`=0; on `imem_rvalid` drop data → REQ.
- `imem_addr` may change while `imem_req`=1 and unaccepted only on a redirect.
- PC arithmetic is 16-bit modulo; 16'hFFFE + 2 = 16'h0000, no flag.
- `err` sets when `imem_rvalid`=1 in REQ, HOLD or HALT. It stays set until reset and has no effect on flow.

## Timing
- Reset values: `pc`=`RESET_PC`, state REQ, `instr`=16'h0800 (NOP), `PC_out`=16'h0000, `instr_valid`=0, `halted`=0, `err`=0. `imem_req`=0 while `rst` is high; `imem_req`=1 in the first cycle after release.
- Reset mid-transaction abandons the outstanding response. Memory is reset by the same `rst`.
- With zero-wait memory (`imem_ready`=1, `imem_rvalid` the next cycle): one instruction every 2 cycles. The first `instr_valid` comes 2 cycles after reset release.
- `stall` and redirect are sampled on the same edge; the IF/ID update is visible the next cycle.
- `imem_req`, `imem_addr` and `halted` are decoded from state and `pc` only, with no combinational path from inputs.

## Configuration
- `FETCH_HALT_DETECT_EN` defined:
  - When an instruction with `[15:11]`=5'b00000 loads into IF/ID, from WAIT or from the skid: → HALT, `halted`=1, no further requests.
  - A redirect exits HALT to REQ and clears `halted`.
- Undefined: HALT state absent, `halted` tied 0, and opcode 00000 is fetched through like any other instruction.

## Test plan
- Reset with `RESET_PC`=16'h0100 and zero-wait memory returning 16'hC123 → `imem_addr`=0x0100 in cycle 1; `instr`=16'hC123, `PC_out`=16'h0102, `instr_valid`=1 in cycle 3.
- IF/ID valid with `stall`=1 for 4 cycles while 16'h4A05 returns → skid holds it with no new request; 1 cycle after `stall` drops, `instr`=16'h4A05 and the next `imem_addr` is issued.
- Redirect to 16'h0040 while in WAIT → the late response 16'hDEAD is dropped, `instr_valid`=0, the next request has `imem_addr`=0x0040, and 16'hDEAD never appears on `instr`.
- Redirect on the same cycle as `imem_rvalid` with `stall`=1 → IF/ID and skid are cleared and the next `imem_addr`=`newPC`.
- `FETCH_HALT_DETECT_EN` set and 16'h0000 fetched at 0x0010 → `halted`=1, `imem_req` stays 0 for 10 cycles; redirect to 0x0020 → `halted`=0 and `imem_addr`=0x0020.
- `imem_rvalid` pulsed in REQ → `err`=1 and stays 1 until `rst`; fetch addresses are unaffected.

Source files
------------

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch stage plus the IF/ID pipeline register. Holds the
// architectural PC and keeps at most one request outstanding to instruction
// memory (req/ready handshake for the request, rvalid for the response).
// A one-entry skid buffer catches a response that returns while decode is
// stalled with a full IF/ID. A redirect from execute discards in-flight work;
// a response that is already owed by memory is absorbed in DRAIN.
//
// Optional feature macro: FETCH_HALT_DETECT_EN
//   defined   - an instruction with opcode [15:11] == 5'b00000 entering IF/ID
//               stops fetching (HALT state, halted = 1) until a redirect.
//   undefined - no HALT state; halted is tied low and opcode 00000 is fetched
//               like any other instruction.
//
// Ports
//   clk            in   system clock, rising edge
//   rst            in   asynchronous active-high reset
//   take_branch_PC in   redirect strobe from execute
//   newPC          in   redirect target
//   stall          in   decode cannot accept IF/ID this cycle
//   imem_req       out  fetch request valid
//   imem_addr      out  fetch address (current PC)
//   imem_ready     in   memory accepts the request this cycle
//   imem_rvalid    in   response data valid
//   imem_rdata     in   instruction word
//   instr          out  IF/ID instruction
//   PC_out         out  IF/ID incremented PC (fetch address + 2)
//   instr_valid    out  IF/ID holds a live instruction
//   halted         out  fetch stopped on a HALT opcode
//   err            out  sticky protocol error (response with nothing owed)
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        take_branch_PC,
    input  logic [15:0] newPC,
    input  logic        stall,
    output logic        imem_req,
    output logic [15:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [15:0] imem_rdata,
    output logic [15:0] instr,
    output logic [15:0] PC_out,
    output logic        instr_valid,
    output logic        halted,
    output logic        err
);

    localparam logic [15:0] NOP_INSTR = 16'h0800;

    typedef enum logic [2:0] {
        S_REQ   = 3'd0,
        S_WAIT  = 3'd1,
        S_DRAIN = 3'd2,
        S_HOLD  = 3'd3
`ifdef FETCH_HALT_DETECT_EN
        ,
        S_HALT  = 3'd4
`endif
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] instr_q, instr_d;
    logic [15:0] pc_out_q, pc_out_d;
    logic        valid_q, valid_d;
    logic [15:0] skid_instr_q, skid_instr_d;
    logic [15:0] skid_pc_q, skid_pc_d;
    logic        err_q, err_d;

    logic [15:0] pc_inc_s;
    logic        ifid_free_s;
    logic        rsp_unowed_s;

    // 16-bit modulo increment: 16'hFFFE wraps to 16'h0000 with no flag
    assign pc_inc_s = pc_q + 16'd2;

    // IF/ID can take a new word if it is empty or decode is consuming it now
    assign ifid_free_s = !valid_q || !stall;

    // Request side depends on state and PC only; rst masks the request while
    // reset is held so nothing is issued before the design is live.
    assign imem_req  = (state_q == S_REQ) && !rst;
    assign imem_addr = pc_q;

    assign instr       = instr_q;
    assign PC_out      = pc_out_q;
    assign instr_valid = valid_q;
    assign err         = err_q;

`ifdef FETCH_HALT_DETECT_EN
    assign halted = (state_q == S_HALT);
`else
    assign halted = 1'b0;
`endif

    // Flag states in which memory owes us nothing, so any rvalid is a protocol error
    always_comb begin
        rsp_unowed_s = 1'b0;
        case (state_q)
            S_REQ:   rsp_unowed_s = 1'b1;
            S_HOLD:  rsp_unowed_s = 1'b1;
`ifdef FETCH_HALT_DETECT_EN
            S_HALT:  rsp_unowed_s = 1'b1;
`endif
            S_WAIT:  rsp_unowed_s = 1'b0;
            S_DRAIN: rsp_unowed_s = 1'b0;
            default: rsp_unowed_s = 1'b0;
        endcase
    end

    // Next-state, PC, IF/ID, skid and error computation
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        instr_d      = instr_q;
        pc_out_d     = pc_out_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;

        // Without a load, an unstalled IF/ID empties into decode (bubble);
        // instr/PC_out keep their last value.
        if (stall) begin
            valid_d = valid_q;
        end else begin
            valid_d = 1'b0;
        end

        if (imem_rvalid && rsp_unowed_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end

        if (take_branch_PC) begin
            // Redirect wins over everything; the skid is simply abandoned by
            // never returning to HOLD with it.
            pc_d    = newPC;
            valid_d = 1'b0;
            case (state_q)
                S_REQ: begin
                    // An accepted request still has a response on its way
                    if (imem_ready) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (imem_rvalid) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
                default: state_d = S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (imem_ready) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_REQ;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid) begin
                        pc_d = pc_inc_s;
                        if (ifid_free_s) begin
                            instr_d  = imem_rdata;
                            pc_out_d = pc_inc_s;
                            valid_d  = 1'b1;
`ifdef FETCH_HALT_DETECT_EN
                            if (imem_rdata[15:11] == 5'b00000) begin
                                state_d = S_HALT;
                            end else begin
                                state_d = S_REQ;
                            end
`else
                            state_d  = S_REQ;
`endif
                        end else begin
                            skid_instr_d = imem_rdata;
                            skid_pc_d    = pc_inc_s;
                            state_d      = S_HOLD;
                        end
                    end else begin
                        state_d = S_WAIT;
                    end
                end
                S_HOLD: begin
                    if (!stall) begin
                        instr_d  = skid_instr_q;
                        pc_out_d = skid_pc_q;
                        valid_d  = 1'b1;
`ifdef FETCH_HALT_DETECT_EN
                        if (skid_instr_q[15:11] == 5'b00000) begin
                            state_d = S_HALT;
                        end else begin
                            state_d = S_REQ;
                        end
`else
                        state_d  = S_REQ;
`endif
                    end else begin
                        state_d = S_HOLD;
                    end
                end
                S_DRAIN: begin
                    // Owed response arrives and is thrown away
                    if (imem_rvalid) begin
                        state_d = S_REQ;
                    end else begin
                        state_d = S_DRAIN;
                    end
                end
`ifdef FETCH_HALT_DETECT_EN
                S_HALT: begin
                    state_d = S_HALT;
                end
`endif
                default: state_d = S_REQ;
            endcase
        end
    end

    // State register for the FSM, PC, IF/ID, skid and error flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            instr_q      <= NOP_INSTR;
            pc_out_q     <= 16'h0000;
            valid_q      <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= 16'h0000;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            instr_q      <= instr_d;
            pc_out_q     <= pc_out_d;
            valid_q      <= valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            err_q        <= err_d;
        end
    end

endmodule
